// File: rtl/mult_pkg.sv
// Shared types and helpers for the chunked sequential signed multiplier.
// Holds the controller state encoding and the chunk-count helper so the
// top level and any future approximate-core variants agree on both.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices in a WIDTH-bit magnitude.
    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_mult_u.sv
// Purpose: unsigned CHUNK x CHUNK -> 2*CHUNK combinational multiplier core.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller sequences operands.
// Ports: a, b - unsigned chunk operands; z - full-width unsigned product.
// Kept as a separate module so an approximate core can be dropped in later.
module chunk_mult_u #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]   a,
    input  logic [CHUNK-1:0]   b,
    output logic [2*CHUNK-1:0] z
);

    assign z = {{CHUNK{1'b0}}, a} * {{CHUNK{1'b0}}, b};

endmodule

// File: rtl/mult_seq_chunked.sv
// Purpose: sequential signed WIDTH x WIDTH multiplier, one CHUNK x CHUNK partial product per cycle.
// Latency: o_valid rises NPP cycles after the accepting edge; one result per NPP+2 cycles at best.
// Backpressure: result held stable in DONE until i_ready; no operands accepted while busy.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_valid/o_ready/i_a/i_b/i_approx
//        operand handshake; o_valid/i_ready/o_z result handshake; o_busy high in MUL or DONE.
module mult_seq_chunked
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [WIDTH-1:0]     i_a,
    input  logic signed [WIDTH-1:0]     i_b,
    input  logic                        i_approx,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [2*WIDTH-1:0]   o_z,
    output logic                        o_busy
);

    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int NPP = NCH * NCH;
    localparam int PW  = (NPP > 1) ? $clog2(NPP) : 1;
    localparam int ZW  = 2 * WIDTH;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("mult_seq_chunked: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
    // which still fits because the result is treated as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              sign;
    logic              approx_q;
    logic [PW-1:0]     p;
    logic [ZW-1:0]     acc;

    logic              accept;
    logic              last_pp;
    int unsigned       i_idx, j_idx;
    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic [2*CHUNK-1:0] pp;
    logic [ZW-1:0]     term;
    logic [ZW-1:0]     acc_sum;

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state == MUL) || (state == DONE);

    assign accept  = i_valid && o_ready;
    assign last_pp = (p == PW'(NPP - 1));

    // Partial-product index p walks chunks of |a| in the outer loop and
    // chunks of |b| in the inner loop.
    always_comb begin
        i_idx   = 32'(p) / NCH;
        j_idx   = 32'(p) % NCH;
        a_chunk = CHUNK'(a_mag >> (CHUNK * i_idx));
        b_chunk = CHUNK'(b_mag >> (CHUNK * j_idx));
    end

    chunk_mult_u #(
        .CHUNK (CHUNK)
    ) u_chunk_mult (
        .a (a_chunk),
        .b (b_chunk),
        .z (pp)
    );

    // Approximate mode drops the lowest-order product but keeps its cycle,
    // so latency is identical in both modes.
    always_comb begin
        term = ZW'(pp) << (CHUNK * (i_idx + j_idx));
        if (approx_q && (p == '0)) begin
            term = '0;
        end
        acc_sum = acc + term;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = MUL;
            MUL:     if (last_pp) state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_mag    <= '0;
            b_mag    <= '0;
            sign     <= 1'b0;
            approx_q <= 1'b0;
            p        <= '0;
            acc      <= '0;
            o_z      <= '0;
        end else begin
            if (accept) begin
                a_mag    <= mag(i_a);
                b_mag    <= mag(i_b);
                sign     <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                approx_q <= i_approx;
                p        <= '0;
                acc      <= '0;
            end else if (state == MUL) begin
                acc <= acc_sum;
                p   <= p + PW'(1);
                if (last_pp) begin
                    // Negating zero gives zero, so no negative-zero case arises.
                    o_z <= sign ? -$signed(acc_sum) : $signed(acc_sum);
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_chunked.sv
module tb_mult_seq_chunked;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic signed [15:0] i_a;
    logic signed [15:0] i_b;
    logic               i_approx;
    logic               o_valid;
    logic               i_ready;
    logic signed [31:0] o_z;
    logic               o_busy;

    logic               w_valid;
    logic               w_ready_o;
    logic signed [23:0] w_a;
    logic signed [23:0] w_b;
    logic               w_approx;
    logic               w_valid_o;
    logic               w_ready;
    logic signed [47:0] w_z;
    logic               w_busy;

    int checks   = 0;
    int failures = 0;

    mult_seq_chunked #(.WIDTH(16), .CHUNK(8)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_approx (i_approx),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_z      (o_z),
        .o_busy   (o_busy)
    );

    mult_seq_chunked #(.WIDTH(24), .CHUNK(8)) dut24 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (w_valid),
        .o_ready  (w_ready_o),
        .i_a      (w_a),
        .i_b      (w_b),
        .i_approx (w_approx),
        .o_valid  (w_valid_o),
        .i_ready  (w_ready),
        .o_z      (w_z),
        .o_busy   (w_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic               approx;
        logic signed [31:0] z;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one operation on the 16-bit DUT, scramble the inputs while it
    // runs, and return the result and accept-to-valid latency.
    task automatic run_op(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic ap, output logic signed [31:0] z, output int lat);
        chk("accept_ready", 64'(o_ready), 64'd1);
        i_a = a; i_b = b; i_approx = ap; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_a = ~a; i_b = a ^ b; i_approx = ~ap;
        lat = 0;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        z = o_z;
    endtask

    task automatic pop();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic run_op24(input logic signed [23:0] a, input logic signed [23:0] b,
                            output logic signed [47:0] z, output int lat);
        w_a = a; w_b = b; w_approx = 1'b0; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        w_a = ~a; w_b = ~b; w_approx = 1'b1;
        lat = 0;
        while (!w_valid_o && lat < 60) begin
            tick();
            lat++;
        end
        z = w_z;
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
    endtask

    initial begin
        logic signed [31:0] z;
        logic signed [47:0] z24;
        logic signed [23:0] ra, rb;
        logic signed [47:0] exp24;
        int lat;

        vecs[0]  = '{a: 16'sd1000,   b: -16'sd3,     approx: 1'b0, z: -32'sd3000};
        vecs[1]  = '{a: -16'sd32768, b: -16'sd32768, approx: 1'b0, z: 32'sd1073741824};
        vecs[2]  = '{a: -16'sd32768, b: 16'sd32767,  approx: 1'b0, z: -32'sd1073709056};
        vecs[3]  = '{a: 16'sd129,    b: 16'sd129,    approx: 1'b1, z: 32'sd0};
        vecs[4]  = '{a: 16'sd129,    b: 16'sd129,    approx: 1'b0, z: 32'sd16641};
        vecs[5]  = '{a: -16'sd129,   b: 16'sd129,    approx: 1'b1, z: 32'sd0};
        vecs[6]  = '{a: 16'sd0,      b: -16'sd5,     approx: 1'b0, z: 32'sd0};
        vecs[7]  = '{a: 16'sd255,    b: 16'sd256,    approx: 1'b1, z: 32'sd65280};
        vecs[8]  = '{a: 16'sd256,    b: -16'sd256,   approx: 1'b0, z: -32'sd65536};
        vecs[9]  = '{a: -16'sd1,     b: -16'sd1,     approx: 1'b0, z: 32'sd1};
        vecs[10] = '{a: -16'sd1,     b: -16'sd1,     approx: 1'b1, z: 32'sd0};
        vecs[11] = '{a: 16'sd32767,  b: 16'sd32767,  approx: 1'b0, z: 32'sd1073676289};

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_approx = 1'b0;
        w_valid = 1'b0; w_ready = 1'b0; w_a = '0; w_b = '0; w_approx = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_z",     64'(o_z),     64'd0);
        chk("rst_busy",  64'(o_busy),  64'd0);
        i_rst_n = 1'b1;
        tick();

        for (int k = 0; k < 12; k++) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].approx, z, lat);
            chk($sformatf("vec%0d_z", k), 64'(z), 64'(vecs[k].z));
            chk($sformatf("vec%0d_lat", k), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_busy", k), 64'(o_busy), 64'd1);
            pop();
        end

        // Backpressure: hold the 7x6 result while new requests are offered.
        run_op(16'sd7, 16'sd6, 1'b0, z, lat);
        chk("bp_lat", 64'(lat), 64'd4);
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_a = 16'sd99; i_b = 16'sd99;
            tick();
            i_valid = 1'b0;
            chk($sformatf("bp_valid%0d", k), 64'(o_valid), 64'd1);
            chk($sformatf("bp_z%0d", k),     64'(o_z),     64'd42);
            chk($sformatf("bp_ready%0d", k), 64'(o_ready), 64'd0);
        end
        pop();
        chk("bp_idle_ready", 64'(o_ready), 64'd1);
        chk("bp_idle_valid", 64'(o_valid), 64'd0);
        chk("bp_idle_busy",  64'(o_busy),  64'd0);

        // Reset in the 2nd MUL cycle takes effect without a clock edge.
        i_a = 16'sd5; i_b = 16'sd5; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("mid_busy", 64'(o_busy), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_z",     64'(o_z),     64'd0);
        #2;
        i_rst_n = 1'b1;
        tick();
        run_op(16'sd300, -16'sd200, 1'b0, z, lat);
        chk("post_rst_z",   64'(z),   -64'sd60000);
        chk("post_rst_lat", 64'(lat), 64'd4);

        // Reset while a result sits in DONE discards it.
        i_rst_n = 1'b0;
        #1;
        chk("done_rst_valid", 64'(o_valid), 64'd0);
        chk("done_rst_z",     64'(o_z),     64'd0);
        #2;
        i_rst_n = 1'b1;
        tick();
        run_op(-16'sd7, 16'sd9, 1'b0, z, lat);
        chk("post_done_rst_z", 64'(z), -64'sd63);
        pop();

        // Wider instance: NPP = 9, checked against a native signed product.
        run_op24(-24'sd8388608, -24'sd8388608, z24, lat);
        chk("w_min_z",   64'(z24), 64'sd70368744177664);
        chk("w_min_lat", 64'(lat), 64'd9);
        for (int k = 0; k < 1000; k++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            exp24 = 48'(longint'(ra) * longint'(rb));
            run_op24(ra, rb, z24, lat);
            chk($sformatf("w_rand%0d_z", k),   64'(z24), 64'(exp24));
            chk($sformatf("w_rand%0d_lat", k), 64'(lat), 64'd9);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq_chunked.md
MULT_SEQ_CHUNKED -- requirements
Module: mult_seq_chunked

Interface
REQ-001 Parameter WIDTH, default 16: signed operand width in bits.
REQ-002 Parameter CHUNK, default 8: width of the unsigned sub-multiplier; WIDTH % CHUNK SHALL be 0, otherwise elaboration fails.
REQ-003 Derived constant NCH = WIDTH/CHUNK; NPP = NCH*NCH partial products.
REQ-004 i_clk  input  1  single clock, rising-edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_valid  input  1  operand request.
REQ-007 o_ready  output  1  block can accept operands.
REQ-008 i_a  input  WIDTH  signed multiplicand.
REQ-009 i_b  input  WIDTH  signed multiplier.
REQ-010 i_approx  input  1  approximate mode request, sampled with the operands.
REQ-011 o_valid  output  1  result available.
REQ-012 i_ready  input  1  downstream accepts the result.
REQ-013 o_z  output  2*WIDTH  signed product.
REQ-014 o_busy  output  1  high in MUL or DONE.

Function
REQ-015 FSM states SHALL be IDLE, MUL and DONE; o_ready = (state==IDLE); o_valid = (state==DONE).
REQ-016 IDLE->MUL on an edge where i_valid&&o_ready; the edge latches |i_a|, |i_b|, sign = i_a[MSB]^i_b[MSB], and i_approx; it also clears the accumulator and the partial-product index p.
REQ-017 Magnitudes SHALL be WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
REQ-018 In MUL, each cycle handles one product: p -> (i = p / NCH, j = p % NCH), chunk i of |a| x chunk j of |b|; the CHUNK x CHUNK unsigned product is shifted left by CHUNK*(i+j) and added to a 2*WIDTH-bit accumulator.
REQ-019 When the latched approx flag is 1, product (0,0) SHALL contribute zero; it still consumes its cycle, so latency is mode-independent.
REQ-020 MUL->DONE on the edge that adds p = NPP-1; that same edge registers o_z as -acc when sign=1, else acc.
REQ-021 Latency: o_valid rises exactly NPP cycles after the accepting edge (4 for defaults).
REQ-022 DONE->IDLE on an edge with i_ready=1; while i_ready=0, o_z and o_valid SHALL hold stable.
REQ-023 No new operand is accepted in DONE or MUL: i_valid is ignored while o_ready=0; throughput is one result per NPP+2 cycles at best.
REQ-024 A zero result with sign=1 SHALL output 0 (no negative zero artefact).
REQ-025 The accumulator SHALL never overflow 2*WIDTH bits; o_z equals the exact signed product when approx=0.
REQ-026 i_a, i_b and i_approx changing during MUL or DONE SHALL have no effect on the result.

Reset
REQ-027 i_rst_n low SHALL force state=IDLE, o_valid=0, o_z=0, accumulator=0, p=0 and sign=0 immediately, without waiting for a clock edge.
REQ-028 Reset mid-MUL or mid-DONE discards the operation; the first accepted request after release produces a correct result.

Structure
REQ-029 Package mult_pkg SHALL hold the state enum (IDLE, MUL, DONE) and a function computing NCH from WIDTH and CHUNK.
REQ-030 One sub-module, chunk_mult_u, SHALL be instantiated exactly once: an unsigned CHUNK x CHUNK -> 2*CHUNK combinational multiplier. It is a swap point for future approximate cores.
REQ-031 Only the accumulator, o_z, magnitudes, sign, approx flag, p and state are registered.

Verification
REQ-032 Defaults: i_a=1000, i_b=-3, approx=0 -> o_valid 4 cycles after accept, o_z=-3000.
REQ-033 i_a=-32768, i_b=-32768 -> o_z=1073741824; i_a=-32768, i_b=32767 -> o_z=-1073709056.
REQ-034 i_a=129, i_b=129, approx=1 -> o_z=0; approx=0 -> o_z=16641; i_a=-129, i_b=129, approx=1 -> o_z=0.
REQ-035 Backpressure: result 7x6 with i_ready=0 for 3 cycles -> o_z=42 and o_valid stable, i_valid pulses meanwhile ignored, IDLE after i_ready=1.
REQ-036 Reset asserted in the 2nd MUL cycle -> o_valid=0 and o_ready=1 at once; next request 300x-200 -> o_z=-60000.
REQ-037 Parameter sweep WIDTH=24, CHUNK=8 (NPP=9): 1000 random signed pairs match the reference model with latency 9.
